// File: rtl/num2str_pkg.sv
// num2str_pkg: shared constants and FSM encoding for the decimal-string scheduler
package num2str_pkg;
  localparam int NUM_OFFSET = 48;
  localparam logic [7:0] BLANK_CHAR = 8'hFF;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
endpackage

// File: rtl/num2str_sched_if.sv
// num2str_sched_if: requester handshakes and OSD string slots
interface num2str_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_NUM = 8
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] str_upd;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*MAX_NUM*8-1:0] str_out;
  logic busy;
  modport master (output req_valid, req_data, input req_ready, str_out, str_upd, busy);
  modport slave (input req_valid, req_data, output req_ready, str_out, str_upd, busy);
endinterface

// File: rtl/dec_digit_engine.sv
// dec_digit_engine: serial divide-by-10, one ASCII digit per cycle, LSD first
module dec_digit_engine
  import num2str_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_NUM = 8,
  parameter int LEADING_ZEROS = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic done,
  output logic [MAX_NUM*8-1:0] str
);
  localparam int DCW = MAX_NUM > 1 ? $clog2(MAX_NUM) : 1;
  logic [DATA_WIDTH-1:0] rem;
  logic [DCW-1:0] d;
  logic run;
  logic [MAX_NUM-1:0][7:0] asm_q;
  logic [7:0] digit;
  // digit 0 is always printed so that a value of zero shows "0"
  assign digit = (LEADING_ZEROS == 0 && d != '0 && rem == '0) ? BLANK_CHAR
               : 8'(rem % DATA_WIDTH'(10)) + 8'(NUM_OFFSET);
  assign done = run && d == DCW'(MAX_NUM - 1);
  assign str = asm_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      d <= '0;
      run <= 1'b0;
      asm_q <= {MAX_NUM{BLANK_CHAR}};
    end else if (start) begin
      rem <= data;
      d <= '0;
      run <= 1'b1;
    end else if (run) begin
      asm_q[d] <= digit;
      rem <= rem / DATA_WIDTH'(10);
      d <= d + DCW'(1);
      run <= !done;
    end
endmodule

// File: rtl/num2str_sched.sv
// num2str_sched: round-robin arbiter feeding one shared decimal engine into per-requester slots
module num2str_sched
  import num2str_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_NUM = 8,
  parameter int LEADING_ZEROS = 0
) (
  input logic clk,
  input logic rst_n,
  num2str_sched_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, g, g_q;
  logic found, start, done;
  int j;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic [NUM_REQ-1:0][MAX_NUM*8-1:0] slot;
  logic [MAX_NUM*8-1:0] eng_str;
  assign data_arr = bus.req_data;
  always_comb begin
    found = 1'b0;
    g = rr_ptr;
    j = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        g = PW'(j);
      end
    end
  end
  assign bus.req_ready = (state == IDLE && found) ? NUM_REQ'(1) << g : '0;
  assign start = |(bus.req_ready & bus.req_valid);
  assign bus.busy = state != IDLE;
  assign bus.str_out = slot;
  dec_digit_engine #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_NUM(MAX_NUM),
    .LEADING_ZEROS(LEADING_ZEROS)
  ) u_eng (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data(data_arr[g]),
    .done(done),
    .str(eng_str)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      g_q <= '0;
      slot <= {NUM_REQ*MAX_NUM{BLANK_CHAR}};
      bus.str_upd <= '0;
    end else begin
      bus.str_upd <= '0;
      if (state == IDLE && start) begin
        state <= CONV;
        g_q <= g;
      end else if (state == CONV && done) begin
        state <= WRITE;
      end else if (state == WRITE) begin
        state <= IDLE;
        slot[g_q] <= eng_str;
        bus.str_upd <= NUM_REQ'(1) << g_q;
        rr_ptr <= g_q == PW'(NUM_REQ - 1) ? '0 : g_q + PW'(1);
      end
    end
endmodule

// File: tb/tb_num2str_sched.sv
// tb_num2str_sched: two instances (blank and zero padding) driven by the same requests
module tb_num2str_sched;
  localparam int NR = 4, DW = 32, MN = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  num2str_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_NUM(MN)) b0 ();
  num2str_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_NUM(MN)) b1 ();
  assign b1.req_valid = b0.req_valid;
  assign b1.req_data = b0.req_data;
  num2str_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_NUM(MN), .LEADING_ZEROS(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  num2str_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_NUM(MN), .LEADING_ZEROS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_cmp = 0, n_err = 0;
  int ptr = 0;
  logic [63:0] m0 [NR];
  logic [63:0] m1 [NR];

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // decimal positions straight from powers of ten
  function automatic logic [63:0] ref_str(input logic [31:0] v, input bit lz);
    logic [63:0] s;
    longint p, q;
    s = '1;
    p = 1;
    for (int i = 0; i < MN; i++) begin
      q = longint'(v) / p;
      s[i*8 +: 8] = (!lz && i > 0 && q == 0) ? 8'hFF : 8'(48 + q % 10);
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [NR-1:0] oh(input int k);
    return NR'(1) << k;
  endfunction

  function automatic int first_from(input logic [NR-1:0] m, input int p);
    for (int i = 0; i < NR; i++) if (m[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic check_slots(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_blank_slot%0d", tag, k), b0.str_out[k*64 +: 64], m0[k]);
      chk($sformatf("%s_zero_slot%0d", tag, k), b1.str_out[k*64 +: 64], m1[k]);
    end
  endtask

  task automatic check_reset(input string tag);
    check_slots(tag);
    chk({tag, "_upd"}, {b0.str_upd, b1.str_upd}, '0);
    chk({tag, "_busy"}, {b0.busy, b1.busy}, '0);
    chk({tag, "_ready"}, {b0.req_ready, b1.req_ready}, '0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < NR; k++) begin
      m0[k] = '1;
      m1[k] = '1;
    end
    ptr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    b0.req_valid = '0;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // single requester from IDLE: handshake cycle 0, slot visible cycle MN+2
  task automatic xfer(input int k, input logic [31:0] v);
    @(negedge clk);
    b0.req_valid = oh(k);
    b0.req_data[k*32 +: 32] = v;
    #1;
    chk($sformatf("xfer_ready_req%0d", k), {b0.req_ready, b1.req_ready}, {oh(k), oh(k)});
    ptr = (k + 1) % NR;
    @(negedge clk);
    b0.req_valid = '0;
    for (int c = 1; c <= MN + 1; c++) begin
      #1;
      chk($sformatf("xfer_busy_c%0d", c), {b0.busy, b1.busy}, 2'b11);
      chk($sformatf("xfer_upd_c%0d", c), {b0.str_upd, b1.str_upd}, '0);
      @(negedge clk);
    end
    #1;
    m0[k] = ref_str(v, 1'b0);
    m1[k] = ref_str(v, 1'b1);
    chk($sformatf("xfer_upd_req%0d", k), {b0.str_upd, b1.str_upd}, {oh(k), oh(k)});
    chk("xfer_busy_done", {b0.busy, b1.busy}, 2'b00);
    check_slots($sformatf("xfer_v%0d", v));
    @(negedge clk);
    #1;
    chk("xfer_upd_drop", {b0.str_upd, b1.str_upd}, '0);
  endtask

  // hold a set of requesters valid and follow n grants through the rotation
  task automatic run_contended(input logic [NR-1:0] mask, input int n);
    logic [31:0] d [NR];
    logic [NR-1:0] exp_rdy;
    int got, pend, age, cyc;
    got = 0; pend = -1; age = -1; cyc = 0;
    for (int k = 0; k < NR; k++) begin
      d[k] = (k % 2 == 0) ? $urandom : $urandom_range(0, 9999);
      b0.req_data[k*32 +: 32] = d[k];
    end
    @(negedge clk);
    b0.req_valid = mask;
    while ((got < n || pend >= 0) && cyc < 400) begin
      if (got >= n) b0.req_valid = '0;
      #1;
      chk("cont_busy", {b0.busy, b1.busy}, (age >= 1 && age <= MN + 1) ? 2'b11 : 2'b00);
      chk("cont_upd", {b0.str_upd, b1.str_upd},
          (pend >= 0 && age == MN + 2) ? {oh(pend), oh(pend)} : '0);
      if (pend >= 0 && age == MN + 2) begin
        m0[pend] = ref_str(d[pend], 1'b0);
        m1[pend] = ref_str(d[pend], 1'b1);
        chk($sformatf("cont_blank_slot%0d", pend), b0.str_out[pend*64 +: 64], m0[pend]);
        chk($sformatf("cont_zero_slot%0d", pend), b1.str_out[pend*64 +: 64], m1[pend]);
        pend = -1;
      end
      exp_rdy = (b0.req_valid != '0 && !(age >= 1 && age <= MN + 1))
              ? oh(first_from(b0.req_valid, ptr)) : '0;
      chk("cont_ready", {b0.req_ready, b1.req_ready}, {exp_rdy, exp_rdy});
      if (exp_rdy != '0) begin
        pend = first_from(b0.req_valid, ptr);
        ptr = (pend + 1) % NR;
        age = 0;
        got++;
      end
      @(negedge clk);
      if (age >= 0) age++;
      cyc++;
    end
    b0.req_valid = '0;
    if (cyc >= 400) begin
      n_cmp++;
      n_err++;
      $error("FAIL cont_timeout observed=%0d grants expected=%0d", got, n);
    end
  endtask

  initial begin
    b0.req_valid = '0;
    b0.req_data = '0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    xfer(2, 32'd12345);
    xfer(0, 32'd0);
    xfer(1, 32'd42);
    xfer(3, 32'd123456789);
    xfer(1, 32'd99999999);
    xfer(0, 32'hFFFF_FFFF);
    do_reset();
    run_contended(4'hF, 4);
    run_contended(4'b1001, 6);
    for (int t = 0; t < 6; t++) run_contended(4'($urandom_range(1, 15)), $urandom_range(1, 5));
    for (int t = 0; t < 6; t++) xfer($urandom_range(0, NR - 1), $urandom_range(0, 999999));
    // abort in the 4th conversion cycle
    do_reset();
    @(negedge clk);
    b0.req_valid = 4'b0010;
    b0.req_data[32 +: 32] = 32'd777;
    @(negedge clk);
    b0.req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_abort_busy", b0.busy, 1'b1);
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_upd", {b0.str_upd, b1.str_upd}, '0);
    end
    check_slots("abort_after");
    xfer(1, $urandom);
    xfer(2, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
